// File: rtl/mult_pkg.sv
// Shared definitions for the signed shift-add multiplier controller.
//   state_t    : controller states
//   MULT_WIDTH : default multiplier width / iteration count
package mult_pkg;

   localparam int MULT_WIDTH = 8;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      ADD,
      SHIFT,
      DONE
   } state_t;

endpackage

// File: rtl/multiplier_control_iter_counter.sv
// Iteration counter for the multiplier controller. Counts 0..WIDTH-1.
// Ports:
//   clk    : clock, all updates on the rising edge
//   clear  : synchronous clear to zero (highest priority)
//   enable : increment by one
//   last   : high while the count equals WIDTH-1
module iter_counter
   import mult_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH
) (
   input  logic clk,
   input  logic clear,
   input  logic enable,
   output logic last
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [CNT_W-1:0] count;

   // Clear wins over enable so a reset or a new start always begins at bit 0.
   always_ff @(posedge clk) begin
      if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CNT_W'(1);
      end
   end

   assign last = (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/multiplier_control.sv
// Sequencing controller for the 8-bit signed shift-add multiplier.
// Runs one add-then-shift iteration per multiplier bit and subtracts in the
// final iteration to apply the two's-complement sign weight.
// Ports:
//   Clk          : clock
//   Reset        : synchronous, active-high reset
//   Run          : level start request
//   ClearA_LoadB : request to load B from the switches while idle
//   M            : current multiplier LSB (B[0])
//   Clr_XA       : clear A and x
//   Ld_XA        : load adder result into x:A
//   Ld_B         : load B from the switches
//   Shift_En     : arithmetic right shift of x:A:B
//   Sub          : adder select, 1 = A - S, 0 = A + S
//   Done         : product in A:B is valid
module multiplier_control
   import mult_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH
) (
   input  logic Clk,
   input  logic Reset,
   input  logic Run,
   input  logic ClearA_LoadB,
   input  logic M,
   output logic Clr_XA,
   output logic Ld_XA,
   output logic Ld_B,
   output logic Shift_En,
   output logic Sub,
   output logic Done
);

   state_t state;
   state_t next_state;
   logic   cnt_clear;
   logic   cnt_en;
   logic   cnt_last;

   // The counter restarts on reset and whenever an operation is launched, and
   // advances on every SHIFT except the final one so it never wraps.
   assign cnt_clear = Reset | ((state == IDLE) & Run);
   assign cnt_en    = (state == SHIFT) & ~cnt_last;

   iter_counter #(
      .WIDTH(WIDTH)
   ) u_iter_counter (
      .clk    (Clk),
      .clear  (cnt_clear),
      .enable (cnt_en),
      .last   (cnt_last)
   );

   // State register with synchronous reset back to IDLE.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and output decode. Ld_XA, Sub and Ld_B are the only outputs
   // that look at inputs; every output is forced low while Reset is high so
   // the datapath sees no activity during the reset cycle.
   always_comb begin
      next_state = state;
      Clr_XA     = 1'b0;
      Ld_XA      = 1'b0;
      Ld_B       = 1'b0;
      Shift_En   = 1'b0;
      Sub        = 1'b0;
      Done       = 1'b0;

      case (state)
         IDLE: begin
            Ld_B = ClearA_LoadB & ~Run;
            if (Run) begin
               next_state = CLEAR;
            end
         end
         CLEAR: begin
            Clr_XA     = 1'b1;
            next_state = ADD;
         end
         ADD: begin
            Ld_XA      = M;
            Sub        = M & cnt_last;
            next_state = SHIFT;
         end
         SHIFT: begin
            Shift_En = 1'b1;
            if (cnt_last) begin
               next_state = DONE;
            end else begin
               next_state = ADD;
            end
         end
         DONE: begin
            Done = 1'b1;
            if (!Run) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase

      if (Reset) begin
         next_state = IDLE;
         Clr_XA     = 1'b0;
         Ld_XA      = 1'b0;
         Ld_B       = 1'b0;
         Shift_En   = 1'b0;
         Sub        = 1'b0;
         Done       = 1'b0;
      end
   end

endmodule

// File: tb/tb_multiplier_control.sv
// Self-checking bench for multiplier_control (WIDTH = 8).
// Each table entry is one clock cycle: inputs are driven just after the rising
// edge and the six outputs are compared on the falling edge.
// Output vector order: {Clr_XA, Ld_XA, Ld_B, Shift_En, Sub, Done}.
module tb_multiplier_control;

   logic Clk;
   logic Reset;
   logic Run;
   logic ClearA_LoadB;
   logic M;
   logic Clr_XA;
   logic Ld_XA;
   logic Ld_B;
   logic Shift_En;
   logic Sub;
   logic Done;

   int total;
   int bad;

   typedef struct {
      logic       reset;
      logic       run;
      logic       cab;
      logic       m;
      logic [5:0] exp;
      string      name;
   } vec_t;

   vec_t vecs[$];

   multiplier_control dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .Run          (Run),
      .ClearA_LoadB (ClearA_LoadB),
      .M            (M),
      .Clr_XA       (Clr_XA),
      .Ld_XA        (Ld_XA),
      .Ld_B         (Ld_B),
      .Shift_En     (Shift_En),
      .Sub          (Sub),
      .Done         (Done)
   );

   // Free-running 100 MHz clock.
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic push(input logic r, input logic run, input logic cab,
                       input logic m, input logic [5:0] exp, input string nm);
      vec_t v;
      v.reset = r;
      v.run   = run;
      v.cab   = cab;
      v.m     = m;
      v.exp   = exp;
      v.name  = nm;
      vecs.push_back(v);
   endtask

   // Operation cycles first..last_c (cycle 0 = Run sampled in IDLE).
   // M follows a register unit that shifts B on each SHIFT edge, so bit k is
   // presented from the CLEAR cycle onward until the SHIFT of bit k.
   task automatic push_op(input logic [7:0] mask, input logic cab,
                          input int first, input int last_c);
      for (int c = first; c <= last_c; c++) begin
         int         k;
         logic       mb;
         logic [5:0] e;
         k  = (c < 2) ? 0 : (c - 2) / 2;
         mb = mask[k];
         e  = '0;
         if (c == 1) begin
            e[5] = 1'b1;
         end else if (c % 2 == 0) begin
            e[4] = mb;
            e[1] = mb & (k == 7);
         end else begin
            e[2] = 1'b1;
         end
         push(1'b0, 1'b1, cab, mb, e, $sformatf("op_c%0d", c));
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      Reset        = v.reset;
      Run          = v.run;
      ClearA_LoadB = v.cab;
      M            = v.m;
   endtask

   task automatic checkOutput(input string nm, input logic [5:0] exp);
      logic [5:0] act;
      act = {Clr_XA, Ld_XA, Ld_B, Shift_En, Sub, Done};
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %b want %b", nm, act, exp);
      end
   endtask

   task automatic checkValue(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   initial begin
      int clr_cnt;
      int shift_cnt;
      int sub_cnt;
      int done_cyc;
      int cyc;

      total        = 0;
      bad          = 0;
      Reset        = 1'b1;
      Run          = 1'b0;
      ClearA_LoadB = 1'b0;
      M            = 1'b0;

      // Reset held three cycles, then plain idle.
      for (int i = 0; i < 3; i++) push(1'b1, 1'b0, 1'b0, 1'b0, 6'b000000, "reset_hold");
      push(1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, "idle");

      // Ld_B while idle, then Run overrides it.
      push(1'b0, 1'b0, 1'b1, 1'b0, 6'b001000, "ldb_idle");
      push(1'b0, 1'b1, 1'b1, 1'b0, 6'b000000, "run_over_ldb");

      // Full operation with M=1, ClearA_LoadB left high (must be ignored).
      push_op(8'hFF, 1'b1, 1, 17);
      for (int i = 0; i < 5; i++) push(1'b0, 1'b1, 1'b1, 1'b1, 6'b000001, "done_hold");
      push(1'b0, 1'b0, 1'b1, 1'b0, 6'b000001, "done_run_low");
      push(1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, "back_idle");

      // Re-raise Run: multiplier 0x07.
      push(1'b0, 1'b1, 1'b0, 1'b0, 6'b000000, "m07_c0");
      push_op(8'h07, 1'b0, 1, 17);
      for (int i = 0; i < 2; i++) push(1'b0, 1'b1, 1'b0, 1'b0, 6'b000001, "m07_done");
      push(1'b0, 1'b0, 1'b0, 1'b0, 6'b000001, "m07_run_low");
      push(1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, "m07_idle");

      // Reset at cycle 9 (SHIFT of bit 3) with Run held; operation restarts.
      push(1'b0, 1'b1, 1'b0, 1'b1, 6'b000000, "rst_c0");
      push_op(8'hFF, 1'b0, 1, 8);
      push(1'b1, 1'b1, 1'b0, 1'b1, 6'b000000, "rst_mid_shift");
      push(1'b0, 1'b1, 1'b0, 1'b1, 6'b000000, "rst_idle");
      push_op(8'hFF, 1'b0, 1, 17);
      push(1'b0, 1'b1, 1'b0, 1'b1, 6'b000001, "rst_done");
      push(1'b0, 1'b0, 1'b0, 1'b0, 6'b000001, "rst_run_low");
      push(1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, "rst_idle_end");

      foreach (vecs[i]) begin
         @(posedge Clk);
         #1;
         applyStimulus(vecs[i]);
         @(negedge Clk);
         checkOutput(vecs[i].name, vecs[i].exp);
      end

      // Hand-written pass: count pulses and measure latency to Done.
      clr_cnt   = 0;
      shift_cnt = 0;
      sub_cnt   = 0;
      done_cyc  = -1;
      @(posedge Clk);
      #1;
      Run          = 1'b1;
      ClearA_LoadB = 1'b0;
      M            = 1'b1;
      for (cyc = 0; cyc < 100; cyc++) begin
         @(negedge Clk);
         if (Done) begin
            done_cyc = cyc;
            break;
         end
         if (Clr_XA)   clr_cnt++;
         if (Shift_En) shift_cnt++;
         if (Sub)      sub_cnt++;
      end
      checkValue("done_latency", done_cyc, 18);
      checkValue("clr_pulses", clr_cnt, 1);
      checkValue("shift_pulses", shift_cnt, 8);
      checkValue("sub_pulses", sub_cnt, 1);

      @(posedge Clk);
      #1;
      Run = 1'b0;
      @(posedge Clk);
      #1;
      @(negedge Clk);
      checkOutput("count_pass_idle", 6'b000000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
